address_multiplexer: RTL and testbench

Debug read-back block for the processor trainer. It latches an 8-bit address when a UART byte has been received (rx_done), then selects one of eight 32-bit internal processor values onto data_out_32. The selectable values are instruction, PC, control word, A, B, ALU result, register-file word and data-memory word. For register-file and data-memory reads it drives a 5-bit read address and a one-cycle read-enable pulse, then captures the returned word. It sits between the UART receiver and the transmit path.

---
 rtl/address_multiplexer.sv | 118 +++++++++++
 tb/tb_address_multiplexer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/address_multiplexer.sv
// rtl/address_multiplexer.sv - debug read-back selector between UART receiver and transmit path
module address_multiplexer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        rx_done,
    input  logic [7:0]  addr_in_8,
    input  logic [31:0] data_inst_32,
    input  logic [31:0] data_pc_32,
    input  logic [31:0] data_cntl_32,
    input  logic [31:0] data_a_32,
    input  logic [31:0] data_b_32,
    input  logic [31:0] data_alu_32,
    input  logic [31:0] data_rf_32,
    input  logic [31:0] data_dm_32,
    output logic [4:0]  addr_rf_5,
    output logic        read_rf_en,
    output logic [4:0]  addr_dm_5,
    output logic        read_dm_en,
    output logic [31:0] data_out_32
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEL  = 2'd1,
        S_WAIT = 2'd2,
        S_CAP  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [7:0]  addr_reg, addr_reg_n;
    logic        rx_d;
    logic        rx_rise;
    logic [31:0] data_out_n;
    logic [4:0]  addr_rf_n, addr_dm_n;
    logic        read_rf_n, read_dm_n;

    // A command only starts on a fresh rise, so a held strobe launches one command.
    assign rx_rise = rx_done & ~rx_d;

    // State and output registers; Reset aborts any read in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            addr_reg    <= 8'd0;
            rx_d        <= 1'b0;
            data_out_32 <= 32'd0;
            addr_rf_5   <= 5'd0;
            addr_dm_5   <= 5'd0;
            read_rf_en  <= 1'b0;
            read_dm_en  <= 1'b0;
        end else begin
            state       <= state_n;
            addr_reg    <= addr_reg_n;
            rx_d        <= rx_done;
            data_out_32 <= data_out_n;
            addr_rf_5   <= addr_rf_n;
            addr_dm_5   <= addr_dm_n;
            read_rf_en  <= read_rf_n;
            read_dm_en  <= read_dm_n;
        end
    end

    // Next-state and next-output logic; everything holds unless a state changes it.
    always_comb begin
        state_n    = state;
        addr_reg_n = addr_reg;
        data_out_n = data_out_32;
        addr_rf_n  = addr_rf_5;
        addr_dm_n  = addr_dm_5;
        read_rf_n  = 1'b0;
        read_dm_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (rx_rise) begin
                    addr_reg_n = addr_in_8;
                    state_n    = S_SEL;
                end
            end

            S_SEL: begin
                state_n = S_IDLE;
                case (addr_reg[7:5])
                    3'd0: data_out_n = data_inst_32;
                    3'd1: data_out_n = data_pc_32;
                    3'd2: data_out_n = data_cntl_32;
                    3'd3: data_out_n = data_a_32;
                    3'd4: data_out_n = data_b_32;
                    3'd5: data_out_n = data_alu_32;
                    3'd6: begin
                        addr_rf_n = addr_reg[4:0];
                        read_rf_n = 1'b1;
                        state_n   = S_WAIT;
                    end
                    default: begin
                        addr_dm_n = addr_reg[4:0];
                        read_dm_n = 1'b1;
                        state_n   = S_WAIT;
                    end
                endcase
            end

            // Enables drop here, giving memories one cycle to return data.
            S_WAIT: begin
                state_n = S_CAP;
            end

            // Only selects 6 and 7 reach here; bit 5 tells them apart.
            S_CAP: begin
                data_out_n = addr_reg[5] ? data_dm_32 : data_rf_32;
                state_n    = S_IDLE;
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_address_multiplexer.sv
// tb/tb_address_multiplexer.sv - scoreboard bench for address_multiplexer
module tb_address_multiplexer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        rx_done = 1'b0;
    logic [7:0]  addr_in_8 = 8'd0;
    logic [31:0] src [6];
    logic [31:0] data_rf_32 = 32'd0;
    logic [31:0] data_dm_32 = 32'd0;
    logic [4:0]  addr_rf_5, addr_dm_5;
    logic        read_rf_en, read_dm_en;
    logic [31:0] data_out_32;

    logic [31:0] rf_mem [32];
    logic [31:0] dm_mem [32];

    typedef struct {
        int          c0;
        int          done;
        logic [2:0]  sel;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [4:0]  rf_addr;
        logic [4:0]  dm_addr;
    } item_t;

    item_t       q [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [4:0]  m_rf = 5'd0;
    logic [4:0]  m_dm = 5'd0;

    address_multiplexer dut (
        .Clk(Clk), .Reset(Reset), .rx_done(rx_done), .addr_in_8(addr_in_8),
        .data_inst_32(src[0]), .data_pc_32(src[1]), .data_cntl_32(src[2]),
        .data_a_32(src[3]), .data_b_32(src[4]), .data_alu_32(src[5]),
        .data_rf_32(data_rf_32), .data_dm_32(data_dm_32),
        .addr_rf_5(addr_rf_5), .read_rf_en(read_rf_en),
        .addr_dm_5(addr_dm_5), .read_dm_en(read_dm_en),
        .data_out_32(data_out_32)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Behavioural memories: data appears one cycle after the enable is sampled.
    always @(posedge Clk) begin
        if (read_rf_en) data_rf_32 <= rf_mem[addr_rf_5];
        if (read_dm_en) data_dm_32 <= dm_mem[addr_dm_5];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Build the expected response from the command's meaning and queue it.
    task automatic issue(input logic [7:0] cmd, input int hold, input logic [7:0] later_cmd);
        item_t it;
        @(negedge Clk); #1;
        addr_in_8 = cmd;
        rx_done   = 1'b1;
        it.c0  = cyc + 1;
        it.sel = cmd[7:5];
        it.idx = cmd[4:0];
        if (it.sel == 3'd6) begin
            m_rf    = it.idx;
            it.data = rf_mem[it.idx];
            it.done = it.c0 + 3;
        end else if (it.sel == 3'd7) begin
            m_dm    = it.idx;
            it.data = dm_mem[it.idx];
            it.done = it.c0 + 3;
        end else begin
            it.data = src[it.sel];
            it.done = it.c0 + 1;
        end
        it.rf_addr = m_rf;
        it.dm_addr = m_dm;
        q.push_back(it);
        for (int i = 1; i < hold; i++) begin
            @(negedge Clk); #1;
            addr_in_8 = later_cmd;
        end
        @(negedge Clk); #1;
        rx_done   = 1'b0;
        addr_in_8 = later_cmd;
    endtask

    // Monitor: enables checked every cycle, result popped when it is due.
    always @(negedge Clk) begin
        logic exp_rf, exp_dm;
        exp_rf = 1'b0;
        exp_dm = 1'b0;
        if (!Reset) begin
            if (q.size() > 0 && cyc == q[0].c0 + 1) begin
                if (q[0].sel == 3'd6) begin
                    exp_rf = 1'b1;
                    check("addr_rf_5 at pulse", {27'd0, addr_rf_5}, {27'd0, q[0].idx});
                end
                if (q[0].sel == 3'd7) begin
                    exp_dm = 1'b1;
                    check("addr_dm_5 at pulse", {27'd0, addr_dm_5}, {27'd0, q[0].idx});
                end
            end
            check("read_rf_en", {31'd0, read_rf_en}, {31'd0, exp_rf});
            check("read_dm_en", {31'd0, read_dm_en}, {31'd0, exp_dm});
            if (q.size() > 0 && cyc >= q[0].done) begin
                check("result timing", cyc, q[0].done);
                check("data_out_32", data_out_32, q[0].data);
                check("addr_rf_5 held", {27'd0, addr_rf_5}, {27'd0, q[0].rf_addr});
                check("addr_dm_5 held", {27'd0, addr_dm_5}, {27'd0, q[0].dm_addr});
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] sweep [5];
        sweep = '{8'h22, 8'h42, 8'h62, 8'h82, 8'hA2};
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = $urandom;
            dm_mem[i] = $urandom;
        end
        rf_mem[2] = 32'd1;
        dm_mem[2] = 32'd8;
        src = '{32'd3, 32'd2, 32'd4, 32'd5, 32'd6, 32'd7};

        repeat (3) @(negedge Clk);
        check("reset data_out_32", data_out_32, 32'd0);
        check("reset addr_rf_5", {27'd0, addr_rf_5}, 32'd0);
        check("reset addr_dm_5", {27'd0, addr_dm_5}, 32'd0);
        check("reset read_rf_en", {31'd0, read_rf_en}, 32'd0);
        check("reset read_dm_en", {31'd0, read_dm_en}, 32'd0);
        #1 Reset = 1'b0;

        // Held strobe with a changing command byte: one select-0 command only.
        issue(8'h02, 5, 8'hC2);
        src[0] = 32'd99;
        repeat (2) @(negedge Clk);
        #1 check("direct source sampled once", data_out_32, 32'd3);
        src[0] = 32'd3;
        repeat (3) @(negedge Clk);

        for (int i = 0; i < 5; i++) begin
            issue(sweep[i], 1, 8'h00);
            repeat (4) @(negedge Clk);
        end

        issue(8'hC2, 1, 8'h00);
        repeat (4) @(negedge Clk);
        issue(8'hE2, 2, 8'h00);
        repeat (4) @(negedge Clk);

        // Second rise lands while the read is waiting: must be ignored.
        issue(8'hC7, 1, 8'hE9);
        @(negedge Clk); #1 rx_done = 1'b1;
        repeat (5) @(negedge Clk);
        #1 rx_done = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset during the wait cycle aborts the read.
        issue(8'hE3, 1, 8'h00);
        @(negedge Clk); #1;
        Reset = 1'b1;
        q.delete();
        m_rf = 5'd0;
        m_dm = 5'd0;
        @(negedge Clk); #1;
        check("abort data_out_32", data_out_32, 32'd0);
        check("abort read_dm_en", {31'd0, read_dm_en}, 32'd0);
        check("abort read_rf_en", {31'd0, read_rf_en}, 32'd0);
        check("abort addr_dm_5", {27'd0, addr_dm_5}, 32'd0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        issue(8'hE5, 1, 8'h00);
        repeat (4) @(negedge Clk);

        for (int n = 0; n < 40; n++) begin
            int h;
            for (int k = 0; k < 6; k++) src[k] = $urandom;
            h = $urandom_range(1, 3);
            issue(8'($urandom), h, 8'($urandom));
            repeat (4) @(negedge Clk);
        end

        repeat (8) @(negedge Clk);
        check("scoreboard drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
